// File: rtl/pci_arb_pkg.sv
// Shared definitions for the PCI bus arbiter: state encoding, active-low levels, size limits.
package pci_arb_pkg;

  localparam int unsigned MaxMasters = 8;

  localparam logic AssertN   = 1'b0;
  localparam logic DeassertN = 1'b1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StGnt  = 2'd1;
  localparam logic [1:0] StBusy = 2'd2;
  localparam logic [1:0] StDead = 2'd3;

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin picker: first eligible request after ptr, ptr itself searched last.
module pci_rr_picker #(
  parameter int unsigned NumMasters = 4
) (
  input  logic [NumMasters-1:0]         req,
  input  logic [$clog2(NumMasters)-1:0] ptr,
  input  logic [NumMasters-1:0]         excl,
  output logic [$clog2(NumMasters)-1:0] idx,
  output logic                          valid
);

  localparam int unsigned IdxW = $clog2(NumMasters);

  logic [NumMasters-1:0] cand;

  assign cand = req & ~excl;

  always_comb begin : p_pick
    logic [IdxW-1:0] j;
    j     = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 1; i <= NumMasters; i++) begin
      j = IdxW'((32'(ptr) + i) % NumMasters);
      if (!valid && cand[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: round-robin grants, bus parking, one dead cycle per hand-over, grant timeout.
module pci_bus_arbiter
  import pci_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned PARK_MASTER = 0,
  parameter int unsigned GNT_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MASTERS-1:0]         req_n,
  input  logic                           frame,
  input  logic                           irdy,
  output logic [NUM_MASTERS-1:0]         gnt_n,
  output logic [$clog2(NUM_MASTERS)-1:0] owner,
  output logic                           owner_valid,
  output logic                           timeout_evt
);

  localparam int unsigned     IdxW     = $clog2(NUM_MASTERS);
  localparam logic [IdxW-1:0] ParkIdx  = IdxW'(PARK_MASTER);
  localparam logic [IdxW-1:0] PtrReset = IdxW'(NUM_MASTERS - 1);
  localparam logic [7:0]      CntLast  = 8'(GNT_TIMEOUT - 1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MaxMasters) begin : gen_bad_cfg
    $error("pci_bus_arbiter: NUM_MASTERS out of range");
  end

  function automatic logic [NUM_MASTERS-1:0] onehot_n(logic [IdxW-1:0] i);
    logic [NUM_MASTERS-1:0] v;
    v    = {NUM_MASTERS{DeassertN}};
    v[i] = AssertN;
    return v;
  endfunction

  logic [1:0]             state_q, state_d;
  logic [IdxW-1:0]        holder_q, holder_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] excl_q, excl_d;
  logic                   idle_prev_q;
  logic [NUM_MASTERS-1:0] gnt_n_d;
  logic [IdxW-1:0]        owner_d;
  logic                   owner_valid_d;
  logic                   timeout_evt_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] holder_oh;
  logic                   bus_idle;
  logic                   start;
  logic                   holder_req;
  logic                   others_req;
  logic                   grant_any;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_valid;

  assign req        = ~req_n;
  assign holder_oh  = NUM_MASTERS'(1) << holder_q;
  assign bus_idle   = frame & irdy;
  // FRAME# falling out of a bus that was idle on the previous edge.
  assign start      = idle_prev_q & ~frame;
  assign holder_req = |(req & holder_oh);
  assign others_req = |(req & ~holder_oh);
  assign grant_any  = ~&gnt_n;

  pci_rr_picker #(
    .NumMasters(NUM_MASTERS)
  ) u_picker (
    .req  (req),
    .ptr  (ptr_q),
    .excl (excl_q),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  always_comb begin
    state_d       = state_q;
    holder_d      = holder_q;
    ptr_d         = ptr_q;
    cnt_d         = '0;
    excl_d        = excl_q;
    gnt_n_d       = gnt_n;
    owner_d       = owner;
    owner_valid_d = owner_valid;
    timeout_evt_d = 1'b0;

    if (start) begin
      owner_d       = holder_q;
      owner_valid_d = 1'b1;
      ptr_d         = holder_q;
    end else if (bus_idle) begin
      owner_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        holder_d = pick_valid ? pick_idx : ParkIdx;
        gnt_n_d  = onehot_n(holder_d);
        state_d  = StGnt;
      end
      StGnt: begin
        if (start) begin
          state_d = StBusy;
        end else if (bus_idle && others_req && (cnt_q == CntLast)) begin
          timeout_evt_d = 1'b1;
          excl_d        = holder_oh;
          gnt_n_d       = {NUM_MASTERS{DeassertN}};
          state_d       = StDead;
        end else if (!holder_req && pick_valid && (pick_idx != holder_q)) begin
          gnt_n_d = {NUM_MASTERS{DeassertN}};
          state_d = StDead;
        end else if (bus_idle && others_req) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      StBusy: begin
        // Hidden arbitration: the grant can move while the current owner still runs.
        if (pick_valid && (pick_idx != holder_q)) begin
          gnt_n_d = {NUM_MASTERS{DeassertN}};
          state_d = StDead;
        end else if (bus_idle) begin
          state_d = grant_any ? StGnt : StIdle;
        end
      end
      StDead: begin
        holder_d = pick_valid ? pick_idx : ParkIdx;
        gnt_n_d  = onehot_n(holder_d);
        excl_d   = '0;
        state_d  = bus_idle ? StGnt : StBusy;
      end
      default: begin
        gnt_n_d = {NUM_MASTERS{DeassertN}};
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      holder_q    <= ParkIdx;
      ptr_q       <= PtrReset;
      cnt_q       <= '0;
      excl_q      <= '0;
      idle_prev_q <= 1'b0;
      gnt_n       <= {NUM_MASTERS{DeassertN}};
      owner       <= '0;
      owner_valid <= 1'b0;
      timeout_evt <= 1'b0;
    end else begin
      state_q     <= state_d;
      holder_q    <= holder_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      excl_q      <= excl_d;
      idle_prev_q <= bus_idle;
      gnt_n       <= gnt_n_d;
      owner       <= owner_d;
      owner_valid <= owner_valid_d;
      timeout_evt <= timeout_evt_d;
    end
  end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed bench for pci_bus_arbiter (4 initiators, park 0, timeout 16).
module tb_pci_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_n = 4'b1111;
  logic       frame = 1'b1;
  logic       irdy = 1'b1;
  logic [3:0] gnt_n;
  logic [1:0] owner;
  logic       owner_valid;
  logic       timeout_evt;

  int n_cmp = 0;
  int n_err = 0;

  logic       viol = 1'b0;
  logic       tmo_seen;
  logic [3:0] gnt_prev;

  pci_bus_arbiter #(
    .NUM_MASTERS(4),
    .PARK_MASTER(0),
    .GNT_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_n      (req_n),
    .frame      (frame),
    .irdy       (irdy),
    .gnt_n      (gnt_n),
    .owner      (owner),
    .owner_valid(owner_valid),
    .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  // Grant-safety watcher: never two grants, never a direct 0->1/1->0 swap.
  always @(negedge clk) begin
    if (!rst && !$isunknown(gnt_prev) && !$isunknown(gnt_n)) begin
      if ($countones(~gnt_n) > 1) viol <= 1'b1;
      if (|(~gnt_prev & gnt_n) && |(gnt_prev & ~gnt_n)) viol <= 1'b1;
    end
    gnt_prev <= gnt_n;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address phase plus 3 data phases; the waiting requester is granted in hidden arbitration.
  task automatic txn(input logic [1:0] exp_owner, input logic [3:0] cur_gnt,
                     input logic [3:0] nxt_gnt);
    frame = 1'b0; irdy = 1'b1;
    tick();
    chk("txn_owner", 32'(owner), 32'(exp_owner));
    chk("txn_owner_valid", 32'(owner_valid), 32'd1);
    chk("txn_gnt_at_start", 32'(gnt_n), 32'(cur_gnt));
    irdy = 1'b0;
    tick();
    chk("txn_dead_cycle", 32'(gnt_n), 32'hF);
    tick();
    chk("txn_next_gnt", 32'(gnt_n), 32'(nxt_gnt));
    frame = 1'b1;
    tick();
    chk("txn_last_phase_valid", 32'(owner_valid), 32'd1);
    irdy = 1'b1;
    tick();
    chk("txn_end_valid", 32'(owner_valid), 32'd0);
    chk("txn_end_owner", 32'(owner), 32'(exp_owner));
    chk("txn_end_gnt", 32'(gnt_n), 32'(nxt_gnt));
  endtask

  initial begin
    tick();
    tick();
    chk("rst_gnt", 32'(gnt_n), 32'hF);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_owner_valid", 32'(owner_valid), 32'd0);
    chk("rst_timeout", 32'(timeout_evt), 32'd0);

    // Park on 0 with no requests; must never time out.
    rst = 1'b0;
    tick();
    chk("park_gnt", 32'(gnt_n), 32'hE);
    tmo_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      tmo_seen = tmo_seen | timeout_evt;
    end
    chk("park_no_timeout", 32'(tmo_seen), 32'd0);
    chk("park_gnt_hold", 32'(gnt_n), 32'hE);
    chk("park_owner_valid", 32'(owner_valid), 32'd0);

    // Request 3 while parked: dead cycle then grant.
    req_n = 4'b0111;
    tick();
    chk("req3_dead", 32'(gnt_n), 32'hF);
    tick();
    chk("req3_gnt", 32'(gnt_n), 32'h7);

    // 1 and 2 request continuously; grants alternate.
    req_n = 4'b1001;
    tick();
    chk("to1_dead", 32'(gnt_n), 32'hF);
    tick();
    chk("to1_gnt", 32'(gnt_n), 32'hD);
    txn(2'd1, 4'b1101, 4'b1011);
    txn(2'd2, 4'b1011, 4'b1101);
    txn(2'd1, 4'b1101, 4'b1011);

    // 2 holds without FRAME#, 0 requests: timeout after 16 idle cycles.
    req_n = 4'b1010;
    tmo_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      tmo_seen = tmo_seen | timeout_evt;
    end
    chk("tmo_not_early", 32'(tmo_seen), 32'd0);
    chk("tmo_hold_gnt", 32'(gnt_n), 32'hB);
    tick();
    chk("tmo_pulse", 32'(timeout_evt), 32'd1);
    chk("tmo_dead", 32'(gnt_n), 32'hF);
    tick();
    chk("tmo_pulse_end", 32'(timeout_evt), 32'd0);
    chk("tmo_gnt0", 32'(gnt_n), 32'hE);

    // Long burst by 1, then 3 requests mid-burst.
    req_n = 4'b1101;
    tick();
    chk("burst_dead", 32'(gnt_n), 32'hF);
    tick();
    chk("burst_gnt1", 32'(gnt_n), 32'hD);
    frame = 1'b0; irdy = 1'b1;
    tick();
    chk("burst_owner", 32'(owner), 32'd1);
    irdy = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("burst_gnt_kept", 32'(gnt_n), 32'hD);
    req_n = 4'b0101;
    tick();
    chk("hidden_dead", 32'(gnt_n), 32'hF);
    chk("hidden_dead_valid", 32'(owner_valid), 32'd1);
    tick();
    chk("hidden_gnt3", 32'(gnt_n), 32'h7);
    chk("hidden_owner", 32'(owner), 32'd1);
    tick();
    tick();
    chk("hidden_gnt3_hold", 32'(gnt_n), 32'h7);
    chk("hidden_valid_hold", 32'(owner_valid), 32'd1);

    // Reset mid-transaction with FRAME# still low.
    rst = 1'b1;
    tick();
    chk("midrst_gnt", 32'(gnt_n), 32'hF);
    chk("midrst_valid", 32'(owner_valid), 32'd0);
    chk("midrst_owner", 32'(owner), 32'd0);
    chk("midrst_timeout", 32'(timeout_evt), 32'd0);

    // From IDLE a pending request is granted after one cycle (search 0,1,2 from ptr 3).
    rst = 1'b0; frame = 1'b1; irdy = 1'b1; req_n = 4'b1011;
    tick();
    chk("idle_gnt2", 32'(gnt_n), 32'hB);

    chk("gnt_safety", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
